// File: rtl/bram_arb_pkg.sv
// Shared helpers and types for the BRAM port arbiter: width/latency functions
// and the in-flight read tracking record.
package bram_arb_pkg;

    localparam int MAX_NUM_REQ   = 8;
    localparam int MAX_IDX_WIDTH = 3;

    // Ceiling log2, never smaller than 1 so an index always has at least one bit.
    function automatic int clog2(input int value);
        int result;
        int remaining;
        result    = 0;
        remaining = value - 1;
        while (remaining > 0) begin
            result    = result + 1;
            remaining = remaining >> 1;
        end
        return (result < 1) ? 1 : result;
    endfunction

    function automatic int lat_of(input int pipelined);
        return (pipelined != 0) ? 2 : 1;
    endfunction

    typedef struct packed {
        logic                     valid;
        logic [MAX_IDX_WIDTH-1:0] id;
    } inflight_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: scans requesters starting one past rr_ptr
// and selects the first valid one. The pointer register lives in the parent.
module rr_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ   = 2,
    parameter int IDX_WIDTH = clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0]   valid,
    input  logic [IDX_WIDTH-1:0] rr_ptr,
    output logic [NUM_REQ-1:0]   grant,
    output logic [IDX_WIDTH-1:0] grant_idx,
    output logic                 any_grant
);

    localparam logic [IDX_WIDTH:0] NUM_REQ_W = (IDX_WIDTH + 1)'(NUM_REQ);

    logic [IDX_WIDTH:0]   scan_sum [NUM_REQ];
    logic [IDX_WIDTH-1:0] scan_idx [NUM_REQ];
    logic [NUM_REQ-1:0]   scan_hit;

    // Slot gi of the scan is requester (rr_ptr + 1 + gi) mod NUM_REQ; the sum
    // never reaches 2*NUM_REQ, so one conditional subtract replaces the modulo.
    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_scan
            assign scan_sum[gi] = {1'b0, rr_ptr} + (IDX_WIDTH + 1)'(gi + 1);
            assign scan_idx[gi] = IDX_WIDTH'((scan_sum[gi] >= NUM_REQ_W)
                                             ? (scan_sum[gi] - NUM_REQ_W)
                                             : scan_sum[gi]);
            assign scan_hit[gi] = valid[scan_idx[gi]];
        end
    endgenerate

    // Walk from lowest to highest priority so the earliest hit wins last.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        any_grant = |valid;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (scan_hit[i]) begin
                grant_idx = scan_idx[i];
            end
        end
        if (any_grant) begin
            grant[grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/bram_port_arbiter.sv
// Round-robin sharing of one BRAM port between NUM_REQ requesters, with a
// latency-matched in-flight pipeline that routes read data back by requester ID.
module bram_port_arbiter
    import bram_arb_pkg::*;
#(
    parameter int NUM_REQ    = 2,
    parameter int ADDR_WIDTH = 1,
    parameter int DATA_WIDTH = 1,
    parameter int WE_WIDTH   = 1,
    parameter int PIPELINED  = 0,
    parameter int ID_WIDTH   = 1
) (
    input  logic                           CLK,
    input  logic                           RST_N,
    input  logic [NUM_REQ-1:0]             REQ_VALID,
    output logic [NUM_REQ-1:0]             REQ_READY,
    input  logic [NUM_REQ*WE_WIDTH-1:0]    REQ_WE,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]  REQ_ADDR,
    input  logic [NUM_REQ*DATA_WIDTH-1:0]  REQ_DATA,
    output logic                           RSP_VALID,
    output logic [ID_WIDTH-1:0]            RSP_ID,
    output logic [DATA_WIDTH-1:0]          RSP_DATA,
    output logic                           BRAM_EN,
    output logic [WE_WIDTH-1:0]            BRAM_WE,
    output logic [ADDR_WIDTH-1:0]          BRAM_ADDR,
    output logic [DATA_WIDTH-1:0]          BRAM_DI,
    input  logic [DATA_WIDTH-1:0]          BRAM_DO
);

    localparam int LAT       = lat_of(PIPELINED);
    localparam int IDX_WIDTH = clog2(NUM_REQ);
    localparam logic [IDX_WIDTH-1:0] PTR_RESET = IDX_WIDTH'(NUM_REQ - 1);

    logic [WE_WIDTH-1:0]   req_we_arr   [NUM_REQ];
    logic [ADDR_WIDTH-1:0] req_addr_arr [NUM_REQ];
    logic [DATA_WIDTH-1:0] req_data_arr [NUM_REQ];

    logic [NUM_REQ-1:0]    grant;
    logic [IDX_WIDTH-1:0]  grant_idx;
    logic                  any_grant;

    logic [IDX_WIDTH-1:0]  rr_ptr_reg;
    logic [IDX_WIDTH-1:0]  rr_ptr_next;

    logic [WE_WIDTH-1:0]   sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_data;
    logic                  is_read;

    logic [ADDR_WIDTH-1:0] addr_hold_reg;
    logic [DATA_WIDTH-1:0] di_hold_reg;

    inflight_t             stage0_next;
    inflight_t             pipe_reg [LAT];

    generate
        for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_unpack
            assign req_we_arr[gi]   = REQ_WE[gi*WE_WIDTH +: WE_WIDTH];
            assign req_addr_arr[gi] = REQ_ADDR[gi*ADDR_WIDTH +: ADDR_WIDTH];
            assign req_data_arr[gi] = REQ_DATA[gi*DATA_WIDTH +: DATA_WIDTH];
        end
    endgenerate

    rr_arbiter #(
        .NUM_REQ   (NUM_REQ),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_rr_arbiter (
        .valid     (REQ_VALID),
        .rr_ptr    (rr_ptr_reg),
        .grant     (grant),
        .grant_idx (grant_idx),
        .any_grant (any_grant)
    );

    assign sel_we   = req_we_arr[grant_idx];
    assign sel_addr = req_addr_arr[grant_idx];
    assign sel_data = req_data_arr[grant_idx];
    assign is_read  = any_grant && (sel_we == '0);

    assign rr_ptr_next = any_grant ? grant_idx : rr_ptr_reg;

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            rr_ptr_reg <= PTR_RESET;
        end else begin
            rr_ptr_reg <= rr_ptr_next;
        end
    end

    // Remember the last driven address/data so the port pins stay quiet when idle.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            addr_hold_reg <= '0;
            di_hold_reg   <= '0;
        end else if (any_grant) begin
            addr_hold_reg <= sel_addr;
            di_hold_reg   <= sel_data;
        end
    end

    // Grant and enable are masked by reset so nothing transfers while it is held.
    assign REQ_READY = RST_N ? grant : '0;
    assign BRAM_EN   = RST_N & any_grant;
    assign BRAM_WE   = (RST_N && any_grant) ? sel_we : '0;
    assign BRAM_ADDR = any_grant ? sel_addr : addr_hold_reg;
    assign BRAM_DI   = any_grant ? sel_data : di_hold_reg;

    always_comb begin
        stage0_next       = '0;
        stage0_next.valid = is_read;
        stage0_next.id    = MAX_IDX_WIDTH'(grant_idx);
    end

    // One stage per cycle of BRAM read latency; no stall is ever needed because
    // the BRAM returns data a fixed number of cycles after each accepted read.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            for (int s = 0; s < LAT; s++) begin
                pipe_reg[s] <= '0;
            end
        end else begin
            pipe_reg[0] <= stage0_next;
            for (int s = 1; s < LAT; s++) begin
                pipe_reg[s] <= pipe_reg[s-1];
            end
        end
    end

    assign RSP_VALID = pipe_reg[LAT-1].valid;
    assign RSP_ID    = ID_WIDTH'(pipe_reg[LAT-1].id);
    assign RSP_DATA  = BRAM_DO;

endmodule
